// File: rtl/as1_pkg.sv
// Shared definitions for the as1 truth-table function block.
// The default table marks the 4-bit primes {2,3,5,7,11,13}.
package as1_pkg;

  localparam logic [15:0] AS1_PRIME_TT = 16'h28AC;

  typedef logic [3:0] as1_code_t;

  // Reference lookup of one table entry.
  function automatic logic as1_eval(input logic [15:0] tt, input as1_code_t code);
    return tt[code];
  endfunction

endpackage

// File: rtl/as1_lut.sv
// Combinational sum-of-products evaluator for a 16-entry truth table.
// Each set table bit contributes one 4-literal minterm, and the minterms are OR-reduced.
module as1_lut
  import as1_pkg::*;
(
  input  logic [15:0] tt,
  input  as1_code_t   in,
  output logic        f
);

  logic [15:0] term;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_term
      localparam as1_code_t CODE = as1_code_t'(gi);
      // XNOR against the code selects each literal as true or complemented.
      assign term[gi] = tt[gi] & (&(in ~^ CODE));
    end
  endgenerate

  assign f = |term;

endmodule

// File: rtl/as1.sv
// 4-input, 1-output Boolean function block with an optional output flop.
// The output flop uses an asynchronous, active-high reset.
module as1
  import as1_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE  = AS1_PRIME_TT,
  parameter bit          REGISTER_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic       out
);

  logic f;

  as1_lut u_lut (
    .tt (TRUTH_TABLE),
    .in (in),
    .f  (f)
  );

  generate
    if (REGISTER_OUT) begin : g_reg
      logic out_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_reg <= 1'b0;
        else     out_reg <= f;
      end

      assign out = out_reg;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out = f;
    end
  endgenerate

endmodule

// File: tb/tb_as1.sv
// Directed testbench for as1: registered prime table, combinational prime table,
// and a single-minterm table (16'h8000).
module tb_as1;

  logic       clk;
  logic       rst;
  logic [3:0] in_r;
  logic [3:0] in_c;
  logic [3:0] in_t;
  logic       out_r;
  logic       out_c;
  logic       out_t;

  int checks;
  int errors;

  // Hand-derived prime sequence for codes 0..15.
  logic exp_prime [16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  as1 dut_reg (
    .clk (clk),
    .rst (rst),
    .in  (in_r),
    .out (out_r)
  );

  as1 #(.REGISTER_OUT(1'b0)) dut_comb (
    .clk (clk),
    .rst (rst),
    .in  (in_c),
    .out (out_c)
  );

  as1 #(.TRUTH_TABLE(16'h8000), .REGISTER_OUT(1'b0)) dut_tt (
    .clk (clk),
    .rst (rst),
    .in  (in_t),
    .out (out_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst  = 1'b1;
    in_r = 4'b0111;
    #3;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got=%b want=0", out_r);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got=%b want=0", out_r);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_no_edge got=%b want=0", out_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge in=7 got=%b want=1", out_r);
    end
    $display("test_reset: in=0111 out=%b", out_r);
  endtask

  task automatic test_sweep_registered();
    logic prev;
    prev = out_r;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_r = 4'(k);
      #1;
      checks++;
      if (out_r !== prev) begin
        errors++;
        $display("FAIL sweep_latency in=%0d got=%b want=%b", k, out_r, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_r !== exp_prime[k]) begin
        errors++;
        $display("FAIL sweep_reg in=%0d got=%b want=%b", k, out_r, exp_prime[k]);
      end
      $display("sweep_reg: in=%0d out=%b", k, out_r);
      prev = exp_prime[k];
    end
  endtask

  task automatic test_sweep_comb();
    for (int k = 0; k < 16; k++) begin
      in_c = 4'(k);
      #5;
      checks++;
      if (out_c !== exp_prime[k]) begin
        errors++;
        $display("FAIL sweep_comb in=%0d got=%b want=%b", k, out_c, exp_prime[k]);
      end
      $display("sweep_comb: in=%0d out=%b", k, out_c);
    end
  endtask

  task automatic test_async_midop();
    @(negedge clk);
    in_r = 4'b1101;
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b1) begin
      errors++;
      $display("FAIL midop_before in=13 got=%b want=1", out_r);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_clear got=%b want=0", out_r);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL midop_released_no_edge got=%b want=0", out_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b1) begin
      errors++;
      $display("FAIL midop_recover in=13 got=%b want=1", out_r);
    end
    $display("test_async_midop: in=1101 out=%b", out_r);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    in_r = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL glitch_setup in=0 got=%b want=0", out_r);
    end
    @(negedge clk);
    #1 in_r = 4'b0010;
    #1 in_r = 4'b0100;
    #1 in_r = 4'b0010;
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL glitch_between_edges got=%b want=0", out_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b1) begin
      errors++;
      $display("FAIL glitch_edge_2 got=%b want=1", out_r);
    end
    @(negedge clk);
    #1 in_r = 4'b0100;
    #1 in_r = 4'b0010;
    #1 in_r = 4'b0100;
    #1;
    checks++;
    if (out_r !== 1'b1) begin
      errors++;
      $display("FAIL glitch_hold got=%b want=1", out_r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_r !== 1'b0) begin
      errors++;
      $display("FAIL glitch_edge_4 got=%b want=0", out_r);
    end
    $display("test_glitch: final in=0100 out=%b", out_r);
  endtask

  task automatic test_single_minterm();
    logic want;
    for (int k = 0; k < 16; k++) begin
      in_t = 4'(k);
      want = (k == 15);
      #5;
      checks++;
      if (out_t !== want) begin
        errors++;
        $display("FAIL tt8000 in=%0d got=%b want=%b", k, out_t, want);
      end
      $display("tt8000: in=%0d out=%b", k, out_t);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    in_r = 4'b0000;
    in_c = 4'b0000;
    in_t = 4'b0000;
    test_reset();
    test_sweep_registered();
    test_sweep_comb();
    test_async_midop();
    test_glitch();
    test_single_minterm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
